// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, registered threshold flags and optional FWFT read port.
// Define FIFO_ERR_FLAGS_EN to add sticky Overflow/Underflow outputs cleared by ERR_CLR.
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_THRESH  = 2**ADDR_WIDTH-4,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic                  WR_EN,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] Dout,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostEmpty,
  output logic                  AlmostFull,
  output logic [ADDR_WIDTH:0]   Count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                  ERR_CLR,
  output logic                  Overflow,
  output logic                  Underflow
`endif
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, count_next;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rd_acc, wr_acc;

  // A write into a full FIFO is only safe when the head is leaving this same cycle.
  assign rd_acc = RD_EN & ~Empty;
  assign wr_acc = WR_EN & (~Full | rd_acc);

  always_comb begin
    count_next = Count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = Count + ONE;
      2'b01:   count_next = Count - ONE;
      default: count_next = Count;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      Count       <= '0;
      Empty       <= 1'b1;
      Full        <= 1'b0;
      AlmostEmpty <= 1'b1;
      AlmostFull  <= 1'b0;
      dout_q      <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE;
        dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      Count       <= count_next;
      Empty       <= (count_next == '0);
      Full        <= (count_next == DEPTH_C);
      AlmostEmpty <= (count_next <= AE_C);
      AlmostFull  <= (count_next >= AF_C);
    end
  end

  // Storage is not reset; contents are only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= Din;
  end

  // FWFT shows the head word directly; when drained it falls back to the last popped word.
  generate
    if (FWFT != 0) begin : g_fwft
      assign Dout = Empty ? dout_q : mem[rd_ptr[ADDR_WIDTH-1:0]];
    end else begin : g_std
      assign Dout = dout_q;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Overflow  <= (WR_EN & ~wr_acc) | (Overflow  & ~ERR_CLR);
      Underflow <= (RD_EN & Empty)   | (Underflow & ~ERR_CLR);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: two FIFO instances (standard and FWFT) driven by identical stimulus.
module tb_fifo_sync_flags;

  logic       CLK, RST, WR_EN, RD_EN;
  logic [7:0] Din;
  logic [7:0] dout0, dout1;
  logic       emp0, ful0, ae0, af0, emp1, ful1, ae1, af1;
  logic [2:0] cnt0, cnt1;
  logic [6:0] st0, st1;
  int         n_vec = 0;
  int         n_err = 0;
`ifdef FIFO_ERR_FLAGS_EN
  logic       ERR_CLR, ovf0, unf0, ovf1, unf1;
`endif

  assign st0 = {cnt0, emp0, ful0, ae0, af0};
  assign st1 = {cnt1, emp1, ful1, ae1, af1};

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_std (
    .CLK(CLK), .RST(RST), .Din(Din), .WR_EN(WR_EN), .RD_EN(RD_EN), .Dout(dout0),
    .Empty(emp0), .Full(ful0), .AlmostEmpty(ae0), .AlmostFull(af0), .Count(cnt0)
`ifdef FIFO_ERR_FLAGS_EN
    , .ERR_CLR(ERR_CLR), .Overflow(ovf0), .Underflow(unf0)
`endif
  );

  fifo_sync_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_fwft (
    .CLK(CLK), .RST(RST), .Din(Din), .WR_EN(WR_EN), .RD_EN(RD_EN), .Dout(dout1),
    .Empty(emp1), .Full(ful1), .AlmostEmpty(ae1), .AlmostFull(af1), .Count(cnt1)
`ifdef FIFO_ERR_FLAGS_EN
    , .ERR_CLR(ERR_CLR), .Overflow(ovf1), .Underflow(unf1)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected {Count, Empty, Full, AlmostEmpty, AlmostFull} for DEPTH=4, AE=1, AF=3.
  function automatic logic [6:0] fl(input int c);
    return {3'(c), c == 0, c == 4, c <= 1, c >= 3};
  endfunction

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    WR_EN = w; RD_EN = r; Din = d;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    RST = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; Din = '0;
`ifdef FIFO_ERR_FLAGS_EN
    ERR_CLR = 1'b0;
`endif
    #1 RST = 1'b1;
    #2;
    if (st0 !== fl(0)) begin n_err++; $display("FAIL reset_st0 got %b want %b", st0, fl(0)); end
    n_vec++;
    if (st1 !== fl(0)) begin n_err++; $display("FAIL reset_st1 got %b want %b", st1, fl(0)); end
    n_vec++;
    if ({dout0, dout1} !== 16'h0) begin n_err++; $display("FAIL reset_dout got %h/%h want 00/00", dout0, dout1); end
    n_vec++;
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'h11 * (i + 1)));
      if (st0 !== fl(i + 1)) begin n_err++; $display("FAIL fill%0d_st0 got %b want %b", i, st0, fl(i + 1)); end
      n_vec++;
      if (st1 !== fl(i + 1)) begin n_err++; $display("FAIL fill%0d_st1 got %b want %b", i, st1, fl(i + 1)); end
      n_vec++;
    end
  endtask

  task automatic test_full_drop_and_read;
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(1'b1, 1'b0, 8'h55);
    if (st0 !== fl(4)) begin n_err++; $display("FAIL drop_st got %b want %b", st0, fl(4)); end
    n_vec++;
    if ({dout0, dout1} !== {8'h00, 8'h11}) begin n_err++; $display("FAIL drop_dout got %h/%h want 00/11", dout0, dout1); end
    n_vec++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      if (dout0 !== exp[i]) begin n_err++; $display("FAIL rd%0d_dout got %h want %h", i, dout0, exp[i]); end
      n_vec++;
      if (st0 !== fl(3 - i)) begin n_err++; $display("FAIL rd%0d_st got %b want %b", i, st0, fl(3 - i)); end
      n_vec++;
      if (dout1 !== ((i < 3) ? exp[i + 1] : 8'h44)) begin n_err++; $display("FAIL rd%0d_fwft got %h", i, dout1); end
      n_vec++;
    end
    drive(1'b0, 1'b1, 8'h00);
    if ({st0, dout0} !== {fl(0), 8'h44}) begin n_err++; $display("FAIL rd_empty got %b/%h want %b/44", st0, dout0, fl(0)); end
    n_vec++;
  endtask

  task automatic test_simul_rw;
    logic [7:0] exp [4];
    exp = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h11 * (i + 1)));
    if (st0 !== fl(4)) begin n_err++; $display("FAIL refill_st got %b want %b", st0, fl(4)); end
    n_vec++;
    drive(1'b1, 1'b1, 8'h66);
    if ({st0, dout0, dout1} !== {fl(4), 8'h11, 8'h22}) begin
      n_err++; $display("FAIL rw_full got %b/%h/%h want %b/11/22", st0, dout0, dout1, fl(4));
    end
    n_vec++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      if ({st0, dout0} !== {fl(3 - i), exp[i]}) begin
        n_err++; $display("FAIL rw_rd%0d got %b/%h want %b/%h", i, st0, dout0, fl(3 - i), exp[i]);
      end
      n_vec++;
      if (dout1 !== ((i < 3) ? exp[i + 1] : 8'h66)) begin n_err++; $display("FAIL rw_rd%0d_fwft got %h", i, dout1); end
      n_vec++;
    end
    drive(1'b1, 1'b1, 8'h77);
    if ({st0, dout0, dout1} !== {fl(1), 8'h66, 8'h77}) begin
      n_err++; $display("FAIL rw_empty got %b/%h/%h want %b/66/77", st0, dout0, dout1, fl(1));
    end
    n_vec++;
    drive(1'b0, 1'b1, 8'h00);
    if ({st0, dout0} !== {fl(0), 8'h77}) begin n_err++; $display("FAIL rw_drain got %b/%h want %b/77", st0, dout0, fl(0)); end
    n_vec++;
  endtask

  task automatic test_fwft;
    drive(1'b1, 1'b0, 8'hA5);
    if ({st1, dout1, dout0} !== {fl(1), 8'hA5, 8'h77}) begin
      n_err++; $display("FAIL fwft_wr got %b/%h/%h want %b/a5/77", st1, dout1, dout0, fl(1));
    end
    n_vec++;
    drive(1'b0, 1'b1, 8'h00);
    if ({st1, dout1, dout0} !== {fl(0), 8'hA5, 8'hA5}) begin
      n_err++; $display("FAIL fwft_pop got %b/%h/%h want %b/a5/a5", st1, dout1, dout0, fl(0));
    end
    n_vec++;
  endtask

  task automatic test_wrap_and_async_reset;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      if ({st0, dout1} !== {fl(1), 8'(i)}) begin n_err++; $display("FAIL wrap_wr%0d got %b/%h", i, st0, dout1); end
      n_vec++;
      drive(1'b0, 1'b1, 8'h00);
      if ({st0, dout0, dout1} !== {fl(0), 8'(i), 8'(i)}) begin
        n_err++; $display("FAIL wrap_rd%0d got %b/%h/%h want %b/%h", i, st0, dout0, dout1, fl(0), 8'(i));
      end
      n_vec++;
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'hC1 + i));
    if ({st0, dout1} !== {fl(3), 8'hC1}) begin n_err++; $display("FAIL pre_rst got %b/%h want %b/c1", st0, dout1, fl(3)); end
    n_vec++;
    WR_EN = 1'b0;
    #2 RST = 1'b1;
    #1;
    if ({st0, st1} !== {fl(0), fl(0)}) begin n_err++; $display("FAIL async_rst_st got %b/%b want %b", st0, st1, fl(0)); end
    n_vec++;
    if ({dout0, dout1} !== 16'h0) begin n_err++; $display("FAIL async_rst_dout got %h/%h want 00/00", dout0, dout1); end
    n_vec++;
    @(posedge CLK); #1 RST = 1'b0;
  endtask

`ifdef FIFO_ERR_FLAGS_EN
  task automatic test_err_flags;
    if ({ovf0, unf0, ovf1, unf1} !== 4'b0000) begin n_err++; $display("FAIL err_init got %b%b want 00", ovf0, unf0); end
    n_vec++;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(i));
    drive(1'b1, 1'b0, 8'hEE);
    if ({ovf0, unf0} !== 2'b10) begin n_err++; $display("FAIL err_ovf got %b%b want 10", ovf0, unf0); end
    n_vec++;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h00);
    if (dout0 !== 8'h03) begin n_err++; $display("FAIL err_drain got %h want 03", dout0); end
    n_vec++;
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    if ({ovf0, unf0, ovf1, unf1} !== 4'b1111) begin n_err++; $display("FAIL err_sticky got %b%b want 11", ovf0, unf0); end
    n_vec++;
    ERR_CLR = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    ERR_CLR = 1'b0;
    if ({ovf0, unf0} !== 2'b00) begin n_err++; $display("FAIL err_clr got %b%b want 00", ovf0, unf0); end
    n_vec++;
    ERR_CLR = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
    ERR_CLR = 1'b0;
    if ({ovf0, unf0} !== 2'b01) begin n_err++; $display("FAIL err_setwins got %b%b want 01", ovf0, unf0); end
    n_vec++;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_full_drop_and_read();
    test_simul_rw();
    test_fwft();
    test_wrap_and_async_reset();
`ifdef FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
